// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu memory/loader block.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_RAM,
    LOAD_HI,
    LOAD_LO,
    RUN,
    HALT
  } loader_state_t;

  localparam logic [15:0] RUN_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/cpu_mem_loader_if.sv
// Host byte-stream, control and core memory bus of the loader.
// The slave side is the memory/loader block.
interface cpu_mem_loader_if #(
  parameter int IMSB = 15,
  parameter int PMSB = 7,
  parameter int AMSB = 7,
  parameter int DMSB = 7
);
  logic            start;
  logic            reload;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_data;
  logic            busy;
  logic            done;
  logic [15:0]     run_cycles;
  logic            cpu_setn;
  logic            cpu_idle;
  logic [PMSB:0]   cpu_pc;
  logic [IMSB:0]   cpu_inst;
  logic [AMSB:0]   cpu_addr;
  logic [DMSB:0]   cpu_rdata;
  logic            cpu_write;
  logic [DMSB:0]   cpu_wdata;

  modport master (
    output start, reload, in_valid, in_data, cpu_idle, cpu_pc, cpu_addr, cpu_write, cpu_wdata,
    input  in_ready, busy, done, run_cycles, cpu_setn, cpu_inst, cpu_rdata
  );

  modport slave (
    input  start, reload, in_valid, in_data, cpu_idle, cpu_pc, cpu_addr, cpu_write, cpu_wdata,
    output in_ready, busy, done, run_cycles, cpu_setn, cpu_inst, cpu_rdata
  );
endinterface

// File: rtl/cpu_sram.sv
// Single-write-port memory with an asynchronous (combinational) read port.
module cpu_sram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu_mem_loader.sv
// Program ROM / data RAM owner for the cpu core, with a byte-stream boot loader
// that fills RAM then ROM (big-endian words) and runs the core until it idles.
module cpu_mem_loader
  import cpu_pkg::*;
#(
  parameter int IMSB = 15,
  parameter int PMSB = 7,
  parameter int AMSB = 7,
  parameter int DMSB = 7
) (
  input  logic             clk,
  input  logic             rstn,
  cpu_mem_loader_if.slave  bus
);

  loader_state_t r_state, w_next;
  logic [AMSB:0] r_ram_ptr;
  logic [PMSB:0] r_rom_ptr;
  logic [7:0]    r_hi;
  logic [15:0]   r_run_cycles;
  logic          r_done;

  logic          w_in_ready, w_busy, w_setn, w_accept;
  logic          w_ram_we, w_rom_we;
  logic [AMSB:0] w_ram_waddr;
  logic [DMSB:0] w_ram_wdata;

  assign w_accept = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, HALT: if (bus.start) w_next = bus.reload ? LOAD_RAM : RUN;
      LOAD_RAM:   if (w_accept && (&r_ram_ptr)) w_next = LOAD_HI;
      LOAD_HI:    if (w_accept) w_next = LOAD_LO;
      LOAD_LO:    if (w_accept) w_next = (&r_rom_ptr) ? RUN : LOAD_HI;
      RUN:        if (bus.cpu_idle) w_next = HALT;
      default:    w_next = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready = 1'b0;
    w_busy     = 1'b1;
    w_setn     = 1'b0;
    case (r_state)
      IDLE, HALT:                 w_busy = 1'b0;
      LOAD_RAM, LOAD_HI, LOAD_LO: w_in_ready = 1'b1;
      RUN:                        w_setn = 1'b1;
      default:                    w_busy = 1'b1;
    endcase
  end

  // Pointers, done pulse and run counter; the counter restarts on every RUN entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ram_ptr    <= '0;
      r_rom_ptr    <= '0;
      r_run_cycles <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= (r_state == RUN) && (w_next == HALT);
      if ((r_state == IDLE || r_state == HALT) && bus.start && bus.reload)
        r_ram_ptr <= '0;
      else if (r_state == LOAD_RAM && w_accept)
        r_ram_ptr <= r_ram_ptr + 1'b1;
      if (r_state == LOAD_RAM && w_accept && (&r_ram_ptr))
        r_rom_ptr <= '0;
      else if (r_state == LOAD_LO && w_accept)
        r_rom_ptr <= r_rom_ptr + 1'b1;
      if (w_next == RUN && r_state != RUN)
        r_run_cycles <= '0;
      else if (r_state == RUN && r_run_cycles != RUN_CNT_MAX)
        r_run_cycles <= r_run_cycles + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == LOAD_HI && w_accept) r_hi <= bus.in_data;
  end

  // Loader and core never write in the same cycle: the core only writes in RUN.
  assign w_ram_we    = (r_state == LOAD_RAM && w_accept) || (r_state == RUN && bus.cpu_write);
  assign w_ram_waddr = (r_state == RUN) ? bus.cpu_addr : r_ram_ptr;
  assign w_ram_wdata = (r_state == RUN) ? bus.cpu_wdata : bus.in_data;
  assign w_rom_we    = (r_state == LOAD_LO) && w_accept;

  cpu_sram #(.AW(AMSB+1), .DW(DMSB+1)) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (bus.cpu_addr),
    .o_rdata (bus.cpu_rdata)
  );

  cpu_sram #(.AW(PMSB+1), .DW(IMSB+1)) u_rom (
    .clk     (clk),
    .i_we    (w_rom_we),
    .i_waddr (r_rom_ptr),
    .i_wdata ({r_hi, bus.in_data}),
    .i_raddr (bus.cpu_pc),
    .o_rdata (bus.cpu_inst)
  );

  assign bus.in_ready   = w_in_ready;
  assign bus.busy       = w_busy;
  assign bus.cpu_setn   = w_setn;
  assign bus.done       = r_done;
  assign bus.run_cycles = r_run_cycles;

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Scoreboard bench for cpu_mem_loader: stream loads, core writes, halt/rerun and resets.
module tb_cpu_mem_loader;

  localparam int RAM_D  = 256;
  localparam int ROM_D  = 256;
  localparam int NBYTES = RAM_D + 2*ROM_D;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cpu_mem_loader_if #(.IMSB(15), .PMSB(7), .AMSB(7), .DMSB(7)) bus();

  cpu_mem_loader #(.IMSB(15), .PMSB(7), .AMSB(7), .DMSB(7)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {S_RDATA, S_INST, S_READY, S_SETN, S_BUSY, S_DONE, S_RUNC} sel_t;
  typedef struct {
    string       name;
    sel_t        sel;
    logic [31:0] exp;
  } chk_t;

  chk_t        q_now[$];
  logic [31:0] q_done[$];

  logic [7:0]  ram_m [RAM_D];
  logic [15:0] rom_m [ROM_D];
  logic [7:0]  img   [NBYTES];
  logic [7:0]  hi_m;

  function automatic logic [31:0] actual(sel_t s);
    case (s)
      S_RDATA: return {24'd0, bus.cpu_rdata};
      S_INST:  return {16'd0, bus.cpu_inst};
      S_READY: return {31'd0, bus.in_ready};
      S_SETN:  return {31'd0, bus.cpu_setn};
      S_BUSY:  return {31'd0, bus.busy};
      S_DONE:  return {31'd0, bus.done};
      default: return {16'd0, bus.run_cycles};
    endcase
  endfunction

  task automatic expect_sig(input string nm, input sel_t s, input logic [31:0] e);
    chk_t c;
    c.name = nm; c.sel = s; c.exp = e;
    q_now.push_back(c);
  endtask

  // Monitor: drains pending level checks and scores every done pulse.
  initial begin : monitor
    chk_t        c;
    logic [31:0] a;
    logic [31:0] e;
    logic        done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      while (q_now.size() > 0) begin
        c = q_now.pop_front();
        a = actual(c.sel);
        n_tests++;
        if (a !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got %0h expected %0h", c.name, a, c.exp);
        end
      end
      if (bus.done === 1'b1) begin
        n_tests++;
        if (done_prev) begin
          n_fail++;
          $display("FAIL done_width: got done high for 2+ cycles expected 1-cycle pulse");
        end else if (q_done.size() == 0) begin
          n_fail++;
          $display("FAIL done_unexpected: got done=1 expected no pulse");
        end else begin
          e = q_done.pop_front();
          if ({16'd0, bus.run_cycles} !== e) begin
            n_fail++;
            $display("FAIL run_cycles: got %0d expected %0d", bus.run_cycles, e);
          end
          n_tests++;
          if (bus.cpu_setn !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_setn: got %b expected 0", bus.cpu_setn);
          end
        end
      end
      done_prev = (bus.done === 1'b1);
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: got no finish expected end of run within 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic rl);
    bus.start  = 1'b1;
    bus.reload = rl;
    tick();
    bus.start  = 1'b0;
    bus.reload = 1'b0;
  endtask

  // Reference effect of stream byte k: RAM bytes first, then ROM words high byte first.
  task automatic model_byte(input int k, input logic [7:0] b);
    int w;
    if (k < RAM_D) ram_m[k] = b;
    else begin
      w = (k - RAM_D) / 2;
      if (((k - RAM_D) % 2) == 0) hi_m = b;
      else rom_m[w] = {hi_m, b};
    end
  endtask

  task automatic send_bytes(input int from, input int to, input bit gaps);
    int tries;
    for (int k = from; k < to; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          bus.in_data  = 8'($urandom);
          tick();
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = img[k];
      tries = 0;
      while (bus.in_ready !== 1'b1 && tries < 8) begin
        tick();
        tries++;
      end
      if (bus.in_ready !== 1'b1) begin
        n_tests++;
        n_fail++;
        $display("FAIL stream_timeout: got in_ready=%b at byte %0d expected 1", bus.in_ready, k);
        bus.in_valid = 1'b0;
        return;
      end
      tick();
      model_byte(k, img[k]);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_image(input string tag);
    for (int a = 0; a < RAM_D; a++) begin
      bus.cpu_addr = 8'(a);
      bus.cpu_pc   = 8'(a);
      expect_sig({tag, "_ram"}, S_RDATA, {24'd0, ram_m[a]});
      expect_sig({tag, "_rom"}, S_INST,  {16'd0, rom_m[a]});
      tick();
    end
  endtask

  task automatic default_image();
    for (int k = 0; k < RAM_D; k++) img[k] = 8'(k);
    for (int i = 0; i < ROM_D; i++) begin
      img[RAM_D + 2*i]     = 8'(i);
      img[RAM_D + 2*i + 1] = ~8'(i);
    end
  endtask

  task automatic halt_now(input logic [31:0] exp_cycles);
    bus.cpu_idle = 1'b1;
    q_done.push_back(exp_cycles);
    tick();
    bus.cpu_idle = 1'b0;
    expect_sig("halt_setn_lvl", S_SETN, 0);
    expect_sig("halt_busy", S_BUSY, 0);
    tick();
    expect_sig("done_cleared", S_DONE, 0);
    tick();
  endtask

  int run_entry;

  initial begin : stim
    bus.start = 0; bus.reload = 0; bus.in_valid = 0; bus.in_data = 0;
    bus.cpu_idle = 0; bus.cpu_pc = 0; bus.cpu_addr = 0; bus.cpu_write = 0; bus.cpu_wdata = 0;
    expect_sig("por_ready", S_READY, 0);
    expect_sig("por_busy",  S_BUSY,  0);
    expect_sig("por_done",  S_DONE,  0);
    expect_sig("por_runc",  S_RUNC,  0);
    expect_sig("por_setn",  S_SETN,  0);
    tick(); tick();
    rstn = 1'b1;
    tick();
    default_image();

    // Reset mid-stream
    start_cmd(1'b1);
    send_bytes(0, 10, 1'b0);
    bus.in_valid = 1'b1;
    rstn = 1'b0;
    expect_sig("rst_ready", S_READY, 0);
    expect_sig("rst_setn",  S_SETN,  0);
    expect_sig("rst_busy",  S_BUSY,  0);
    expect_sig("rst_done",  S_DONE,  0);
    expect_sig("rst_runc",  S_RUNC,  0);
    tick();
    bus.in_valid = 1'b0;
    rstn = 1'b1;
    tick();

    // Full load, no gaps
    start_cmd(1'b1);
    send_bytes(0, NBYTES - 1, 1'b0);
    expect_sig("pre_last_ready", S_READY, 1);
    expect_sig("pre_last_setn",  S_SETN,  0);
    send_bytes(NBYTES - 1, NBYTES, 1'b0);
    run_entry = cyc;
    expect_sig("run_setn",  S_SETN,  1);
    expect_sig("run_ready", S_READY, 0);
    expect_sig("run_busy",  S_BUSY,  1);
    bus.cpu_addr = 8'd5;
    bus.cpu_pc   = 8'd3;
    expect_sig("ram5", S_RDATA, 32'h05);
    expect_sig("rom3", S_INST,  32'h03FC);
    tick();
    check_image("load");

    // Core write in RUN, visible the next cycle
    bus.cpu_addr  = 8'h10;
    bus.cpu_wdata = 8'hA5;
    bus.cpu_write = 1'b1;
    tick();
    bus.cpu_write = 1'b0;
    ram_m[16] = 8'hA5;
    expect_sig("core_wr", S_RDATA, 32'hA5);
    tick();
    bus.cpu_addr = 8'h11;
    expect_sig("core_wr_nbr", S_RDATA, {24'd0, ram_m[17]});
    tick();
    halt_now(cyc - run_entry + 1);

    // Rerun without reload; stream bytes offered must be ignored
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    start_cmd(1'b0);
    expect_sig("rerun_ready", S_READY, 0);
    expect_sig("rerun_setn",  S_SETN,  1);
    tick(); tick(); tick();
    halt_now(32'd4);
    bus.in_valid = 1'b0;
    check_image("after_rerun");

    // Reload with backpressure gaps restores the image
    start_cmd(1'b1);
    send_bytes(0, NBYTES, 1'b1);
    run_entry = cyc;
    check_image("gaps");
    halt_now(cyc - run_entry + 1);

    // Random partial image, reset at rom_ptr=40, then full reload
    for (int k = 0; k < NBYTES; k++) img[k] = 8'($urandom);
    start_cmd(1'b1);
    send_bytes(0, RAM_D + 80, 1'b1);
    rstn = 1'b0;
    expect_sig("midrom_busy",  S_BUSY,  0);
    expect_sig("midrom_ready", S_READY, 0);
    expect_sig("midrom_setn",  S_SETN,  0);
    tick();
    rstn = 1'b1;
    tick();
    default_image();
    start_cmd(1'b1);
    send_bytes(0, NBYTES, 1'b0);
    run_entry = cyc;
    check_image("reload");
    halt_now(cyc - run_entry + 1);

    tick(); tick();
    n_tests++;
    if (q_done.size() != 0) begin
      n_fail++;
      $display("FAIL done_missing: got %0d pending halts expected 0", q_done.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
